// File: rtl/fft_buffer_pkg.sv
// fft_buffer_pkg
// Shared definitions for the FFT ping-pong sample buffer:
//   - state_t       : fill-side handshake states (FILL, WAIT)
//   - DEFAULT_*     : default frame geometry (64 words x 32 bits)
//   - bit_reverse() : reverses the low 'width' bits of a value, used when the
//                     BIT_REVERSE_EN macro selects bit-reversed frame loading.
package fft_buffer_pkg;

  typedef enum logic {
    FILL = 1'b0,
    WAIT = 1'b1
  } state_t;

  localparam int DEFAULT_ADDR_W = 6;
  localparam int DEFAULT_DATA_W = 32;

  // Bits at and above 'width' come back as zero, so callers can simply
  // truncate the result to their address width.
  function automatic logic [31:0] bit_reverse(input logic [31:0] value,
                                              input int width);
    logic [31:0] result;
    result = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < width) begin
        result[5'(i)] = value[5'(width - 1 - i)];
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/fft_pingpong_buffer_bank.sv
// buffer_bank
// One simple dual-port sample bank of 2^ADDR_W words x DATA_W bits.
// Ports:
//   clk     : rising-edge clock
//   reset_n : synchronous active-low reset, clears only the read register
//   we      : write enable
//   waddr   : write address
//   wdata   : write data
//   raddr   : read address
//   q       : registered read data, one cycle after raddr
// A read and write to the same address in one cycle returns the old word.
module buffer_bank #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] q
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // Storage array has no reset so it can map onto block RAM.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      q <= '0;
    end else begin
      q <= mem[raddr];
    end
  end

endmodule

// File: rtl/fft_pingpong_buffer.sv
// fft_pingpong_buffer
// Double-buffered sample store for the FFT datapath. One bank fills from the
// streaming input while the FFT core works in place on the other; banks swap
// when a frame is complete and the compute side has released its bank.
// Ports:
//   clk, reset_n         : clock, synchronous active-low reset
//   in_valid/in_data     : streaming sample input
//   in_ready             : input accepted when in_valid & in_ready
//   overflow             : one-cycle pulse per dropped sample
//   frame_ready          : compute bank holds a full, unreleased frame
//   compute_raddr/_q     : compute read port, 1-cycle latency
//   compute_write/_waddr/_d : compute write port, active only with frame_ready
//   compute_done         : pulse releasing the compute bank
//   fill_bank            : index of the filling bank (compute bank is ~fill_bank)
// Build option: define BIT_REVERSE_EN to load frames in bit-reversed address
// order; otherwise samples are written in natural order.
module fft_pingpong_buffer
  import fft_buffer_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W,
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              overflow,
  output logic              frame_ready,
  input  logic [ADDR_W-1:0] compute_raddr,
  output logic [DATA_W-1:0] compute_q,
  input  logic              compute_write,
  input  logic [ADDR_W-1:0] compute_waddr,
  input  logic [DATA_W-1:0] compute_d,
  input  logic              compute_done,
  output logic              fill_bank
);

  state_t            state, state_next;
  logic [ADDR_W-1:0] count, count_next;
  logic              fill_bank_next;
  logic              frame_ready_next;
  logic              read_bank;
  logic              accept;
  logic              last_sample;
  logic [ADDR_W-1:0] fill_addr;
  logic              compute_we;
  logic              we0, we1;
  logic [ADDR_W-1:0] waddr0, waddr1;
  logic [DATA_W-1:0] wdata0, wdata1;
  logic [DATA_W-1:0] q0, q1;

  assign in_ready    = (state == FILL) & reset_n;
  assign accept      = in_valid & in_ready;
  assign last_sample = (count == {ADDR_W{1'b1}});
  assign compute_we  = compute_write & frame_ready;

`ifdef BIT_REVERSE_EN
  assign fill_addr = ADDR_W'(bit_reverse(32'(count), ADDR_W));
`else
  assign fill_addr = count;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= FILL;
      count       <= '0;
      fill_bank   <= 1'b0;
      frame_ready <= 1'b0;
      overflow    <= 1'b0;
      read_bank   <= 1'b0;
    end else begin
      state       <= state_next;
      count       <= count_next;
      fill_bank   <= fill_bank_next;
      frame_ready <= frame_ready_next;
      overflow    <= in_valid & ~in_ready;
      // Remembers which bank answered this cycle's read address.
      read_bank   <= ~fill_bank;
    end
  end

  // Completing a frame swaps immediately when the compute bank is free or is
  // being released in the same cycle; otherwise the input stalls in WAIT.
  always_comb begin
    state_next       = state;
    count_next       = count;
    fill_bank_next   = fill_bank;
    frame_ready_next = frame_ready;
    case (state)
      FILL: begin
        if (accept && last_sample) begin
          count_next = '0;
          if (!frame_ready || compute_done) begin
            fill_bank_next   = ~fill_bank;
            frame_ready_next = 1'b1;
          end else begin
            state_next = WAIT;
          end
        end else begin
          if (accept) begin
            count_next = count + 1'b1;
          end
          if (compute_done && frame_ready) begin
            frame_ready_next = 1'b0;
          end
        end
      end
      WAIT: begin
        if (compute_done) begin
          fill_bank_next = ~fill_bank;
          state_next     = FILL;
        end
      end
      default: state_next = FILL;
    endcase
  end

  // Each bank's write port is owned by whichever side currently holds it.
  always_comb begin
    we0    = 1'b0;
    we1    = 1'b0;
    waddr0 = compute_waddr;
    waddr1 = compute_waddr;
    wdata0 = compute_d;
    wdata1 = compute_d;
    if (fill_bank == 1'b0) begin
      we0    = accept;
      waddr0 = fill_addr;
      wdata0 = in_data;
      we1    = compute_we;
    end else begin
      we1    = accept;
      waddr1 = fill_addr;
      wdata1 = in_data;
      we0    = compute_we;
    end
  end

  buffer_bank #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bank0 (
    .clk     (clk),
    .reset_n (reset_n),
    .we      (we0),
    .waddr   (waddr0),
    .wdata   (wdata0),
    .raddr   (compute_raddr),
    .q       (q0)
  );

  buffer_bank #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bank1 (
    .clk     (clk),
    .reset_n (reset_n),
    .we      (we1),
    .waddr   (waddr1),
    .wdata   (wdata1),
    .raddr   (compute_raddr),
    .q       (q1)
  );

  assign compute_q = read_bank ? q1 : q0;

endmodule
